// File: rtl/cabac_pkg.sv
// Shared CABAC decoder types and constants.
// Used by the bits tracker and its optional stats block.
package cabac_pkg;

  localparam int CABAC_BYTE_W  = 8;
  localparam int REG_MAX_SHIFT = 7;
  localparam int BN_INIT       = -8;

  typedef enum logic {
    BT_IDLE,
    BT_FETCH
  } bt_state_t;

endpackage

// File: rtl/cabac_bits_stats.sv
// Byte and stall counters for the bits tracker.
// Built only with CABAC_BITS_TRACKER_STATS_EN.
module cabac_bits_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        byte_fire,
  input  logic        stall,
  output logic [31:0] stat_bytes,
  output logic [31:0] stat_stalls
);

  logic [31:0] bytes_q, bytes_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    bytes_d  = bytes_q;
    stalls_d = stalls_q;
    if (init) begin
      bytes_d  = '0;
      stalls_d = '0;
    end else begin
      if (byte_fire) bytes_d  = bytes_q + 32'd1;
      if (stall)     stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q  <= '0;
      stalls_q <= '0;
    end else begin
      bytes_q  <= bytes_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_bytes  = bytes_q;
  assign stat_stalls = stalls_q;

endmodule

// File: rtl/cabac_bits_tracker.sv
// CABAC bitsNeeded counter with byte fetch from the bitstream FIFO.
// Optional stats outputs: define CABAC_BITS_TRACKER_STATS_EN.
module cabac_bits_tracker
  import cabac_pkg::*;
#(
  parameter  int MAX_BYPASS_BITS = 16,
  parameter  int BYTE_W          = 8,
  localparam int CNT_W = $clog2(MAX_BYPASS_BITS + 8) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_bypass,
  input  logic [4:0]        op_numbits,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              ld_valid,
  output logic [BYTE_W-1:0] ld_byte,
  output logic [4:0]        ld_shift,
  output logic [CNT_W-1:0]  bits_needed,
  output logic              err
`ifdef CABAC_BITS_TRACKER_STATS_EN
  ,
  output logic [31:0]       stat_bytes,
  output logic [31:0]       stat_stalls
`endif
);

  localparam logic [4:0] BYP_MAX = 5'(MAX_BYPASS_BITS);
  localparam logic [4:0] REG_MAX = 5'(REG_MAX_SHIFT);
  localparam logic [CNT_W-1:0] BN_RST = CNT_W'(BN_INIT);
  localparam logic [CNT_W-1:0] STEP   = CNT_W'(CABAC_BYTE_W);

  bt_state_t state_q, state_d;

  logic [CNT_W-1:0]  bn_q, bn_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              ld_valid_q, ld_valid_d;
  logic [BYTE_W-1:0] ld_byte_q, ld_byte_d;
  logic [4:0]        ld_shift_q, ld_shift_d;
  logic              err_q, err_d;

  logic             illegal;
  logic [4:0]       nb_eff;
  logic [CNT_W-1:0] s;
  logic [CNT_W-1:0] acc_m8;
  logic             byte_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BT_IDLE;
      bn_q       <= BN_RST;
      acc_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_byte_q  <= '0;
      ld_shift_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bn_q       <= bn_d;
      acc_q      <= acc_d;
      ld_valid_q <= ld_valid_d;
      ld_byte_q  <= ld_byte_d;
      ld_shift_q <= ld_shift_d;
      err_q      <= err_d;
    end
  end

  // Illegal counts are clamped to the largest legal shift for the op kind.
  always_comb begin
    if (op_bypass)
      illegal = (op_numbits == 5'd0) || (op_numbits > BYP_MAX);
    else
      illegal = op_numbits > REG_MAX;
    nb_eff = op_numbits;
    if (illegal)
      nb_eff = op_bypass ? BYP_MAX : REG_MAX;
    s      = bn_q + CNT_W'(nb_eff);
    acc_m8 = acc_q - STEP;
  end

  always_comb begin
    state_d    = state_q;
    bn_d       = bn_q;
    acc_d      = acc_q;
    ld_valid_d = 1'b0;
    ld_byte_d  = ld_byte_q;
    ld_shift_d = ld_shift_q;
    err_d      = err_q;
    if (init) begin
      state_d = BT_IDLE;
      bn_d    = BN_RST;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        BT_IDLE: begin
          if (op_valid) begin
            err_d = err_q | illegal;
            if (s[CNT_W-1]) begin
              bn_d = s;
            end else begin
              acc_d   = s;
              state_d = BT_FETCH;
            end
          end
        end
        BT_FETCH: begin
          if (byte_fire) begin
            ld_valid_d = 1'b1;
            ld_byte_d  = byte_data;
            ld_shift_d = acc_q[4:0];
            acc_d      = acc_m8;
            if (acc_m8[CNT_W-1]) begin
              bn_d    = acc_m8;
              state_d = BT_IDLE;
            end
          end
        end
        default: state_d = BT_IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready   = (state_q == BT_IDLE);
    byte_ready = (state_q == BT_FETCH) && !init;
    byte_fire  = byte_valid && byte_ready;
  end

  assign ld_valid    = ld_valid_q;
  assign ld_byte     = ld_byte_q;
  assign ld_shift    = ld_shift_q;
  assign bits_needed = bn_q;
  assign err         = err_q;

`ifdef CABAC_BITS_TRACKER_STATS_EN
  logic stall;
  assign stall = (state_q == BT_FETCH) && !byte_valid && !init;

  cabac_bits_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .byte_fire  (byte_fire),
    .stall      (stall),
    .stat_bytes (stat_bytes),
    .stat_stalls(stat_stalls)
  );
`endif

endmodule

// File: tb/tb_cabac_bits_tracker.sv
// Directed bench for cabac_bits_tracker with a queue-based reference model.
// Stats checks are active when CABAC_BITS_TRACKER_STATS_EN is defined.
module tb_cabac_bits_tracker;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_bypass = 1'b0;
  logic [4:0]        op_numbits = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              op_ready;
  logic              byte_ready;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic [4:0]        ld_shift;
  logic signed [5:0] bits_needed;
  logic              err;
`ifdef CABAC_BITS_TRACKER_STATS_EN
  logic [31:0]       stat_bytes;
  logic [31:0]       stat_stalls;
`endif

  cabac_bits_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_bypass  (op_bypass),
    .op_numbits (op_numbits),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_shift   (ld_shift),
    .bits_needed(bits_needed),
    .err        (err)
`ifdef CABAC_BITS_TRACKER_STATS_EN
    ,
    .stat_bytes (stat_bytes),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  function automatic int eff_bits(input bit b, input int n);
    if (b) return (n == 0 || n > 16) ? 16 : n;
    return (n > 7) ? 7 : n;
  endfunction

  function automatic bit is_illegal(input bit b, input int n);
    if (b) return (n == 0 || n > 16);
    return n > 7;
  endfunction

  // Reference model: an accepted op becomes a list of byte shifts to
  // service, plus the counter value left once the list drains.
  int m_bn;
  int m_pend[$];
  int m_final;
  bit m_err;
  bit m_ldv;
  int m_ldb;
  int m_lds;
  int m_sb;
  int m_ss;

  always @(posedge clk) begin : model
    int s;
    if (!rst_n) begin
      m_bn = -8; m_pend.delete(); m_err = 0;
      m_ldv = 0; m_ldb = 0; m_lds = 0;
      m_sb = 0; m_ss = 0;
    end else if (init) begin
      m_bn = -8; m_pend.delete(); m_err = 0; m_ldv = 0;
      m_sb = 0; m_ss = 0;
    end else begin
      m_ldv = 0;
      if (m_pend.size() == 0) begin
        if (op_valid) begin
          if (is_illegal(op_bypass, int'(op_numbits))) m_err = 1;
          s = m_bn + eff_bits(op_bypass, int'(op_numbits));
          while (s >= 0) begin
            m_pend.push_back(s);
            s -= 8;
          end
          if (m_pend.size() == 0) m_bn = s;
          else m_final = s;
        end
      end else if (byte_valid) begin
        m_ldv = 1;
        m_ldb = int'(byte_data);
        m_lds = m_pend.pop_front();
        m_sb++;
        if (m_pend.size() == 0) m_bn = m_final;
      end else begin
        m_ss++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("bits_needed", int'(bits_needed), m_bn);
      chk("op_ready", int'(op_ready), int'(m_pend.size() == 0));
      chk("byte_ready", int'(byte_ready),
          int'((m_pend.size() != 0) && !init));
      chk("ld_valid", int'(ld_valid), int'(m_ldv));
      chk("err", int'(err), int'(m_err));
      if (m_ldv) begin
        chk("ld_byte", int'(ld_byte), m_ldb);
        chk("ld_shift", int'(ld_shift), m_lds);
      end
`ifdef CABAC_BITS_TRACKER_STATS_EN
      chk("stat_bytes", int'(stat_bytes), m_sb);
      chk("stat_stalls", int'(stat_stalls), m_ss);
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic op(input bit b, input int n);
    op_valid   = 1'b1;
    op_bypass  = b;
    op_numbits = 5'(n);
    tick();
    op_valid   = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    while (!op_ready && w < 10) begin
      tick();
      w++;
    end
    if (w >= 10) chk(nm, 0, 1);
  endtask

  typedef struct { bit b; int n; } op_t;
  op_t tbl[8] = '{'{0, 3}, '{0, 7}, '{1, 5}, '{1, 12},
                  '{0, 1}, '{1, 16}, '{0, 0}, '{0, 6}};

  initial begin
    int sb0;
    int ss0;
    sb0 = 0;
    ss0 = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_bits", int'(bits_needed), -8);
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_byte_ready", int'(byte_ready), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ld_valid", int'(ld_valid), 0);

    op(0, 3);
    chk("reg3_bits", int'(bits_needed), -5);
    chk("reg3_op_ready", int'(op_ready), 1);
    chk("reg3_byte_ready", int'(byte_ready), 0);
    op(0, 3);
    chk("reg3b_bits", int'(bits_needed), -2);

    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    op(0, 5);
    chk("f1_op_ready", int'(op_ready), 0);
    tick();
    chk("f1_ld_valid", int'(ld_valid), 1);
    chk("f1_ld_byte", int'(ld_byte), 8'hA5);
    chk("f1_ld_shift", int'(ld_shift), 3);
    chk("f1_bits", int'(bits_needed), -5);
    chk("f1_op_ready2", int'(op_ready), 1);
    byte_valid = 1'b0;

    op(0, 4);
    chk("pre_byp_bits", int'(bits_needed), -1);
    byte_valid = 1'b1;
    byte_data  = 8'h12;
    op(1, 16);
    tick();
    chk("byp_ld1_byte", int'(ld_byte), 8'h12);
    chk("byp_ld1_shift", int'(ld_shift), 15);
    chk("byp_op_ready1", int'(op_ready), 0);
    byte_data = 8'h34;
    tick();
    chk("byp_ld2_byte", int'(ld_byte), 8'h34);
    chk("byp_ld2_shift", int'(ld_shift), 7);
    chk("byp_bits", int'(bits_needed), -1);
    chk("byp_op_ready2", int'(op_ready), 1);
    byte_valid = 1'b0;

`ifdef CABAC_BITS_TRACKER_STATS_EN
    sb0 = int'(stat_bytes);
    ss0 = int'(stat_stalls);
`endif
    op(0, 1);
    repeat (4) tick();
    chk("stall_op_ready", int'(op_ready), 0);
    chk("stall_bits", int'(bits_needed), -1);
    chk("stall_ld_valid", int'(ld_valid), 0);
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    tick();
    chk("stall_ld_shift", int'(ld_shift), 0);
    chk("stall_bits2", int'(bits_needed), -8);
`ifdef CABAC_BITS_TRACKER_STATS_EN
    chk("stat_bytes_inc", int'(stat_bytes) - sb0, 1);
    chk("stat_stalls_inc", int'(stat_stalls) - ss0, 4);
`endif
    byte_valid = 1'b0;

    op(0, 7);
    op(0, 2);
    init       = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    #1;
    chk("init_byte_ready", int'(byte_ready), 0);
    tick();
    init       = 1'b0;
    byte_valid = 1'b0;
    chk("init_bits", int'(bits_needed), -8);
    chk("init_op_ready", int'(op_ready), 1);
    chk("init_ld_valid", int'(ld_valid), 0);

    op(0, 9);
    chk("ill_err", int'(err), 1);
    chk("ill_bits", int'(bits_needed), -1);
    op(0, 0);
    chk("zero_bits", int'(bits_needed), -1);
    chk("zero_err", int'(err), 1);
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    op(1, 20);
    tick();
    chk("ill_byp_shift1", int'(ld_shift), 15);
    tick();
    chk("ill_byp_shift2", int'(ld_shift), 7);
    chk("ill_byp_bits", int'(bits_needed), -1);
    chk("ill_byp_err", int'(err), 1);
    byte_valid = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_err_clr", int'(err), 0);

    byte_valid = 1'b1;
    foreach (tbl[i]) begin
      byte_data = 8'(8'h30 + i);
      wait_ready("tbl_ready_timeout");
      op(tbl[i].b, tbl[i].n);
    end
    wait_ready("drain_timeout");
    byte_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cabac_bits_tracker.md
# cabac_bits_tracker

Sequential successor to the combinational bits-needed logic of the VVC arithmetic decoder. It owns the signed `bitsNeeded` counter and accepts one bin-consumption operation per handshake: a regular-bin renorm shift or a multi-bit bypass run of up to `MAX_BYPASS_BITS` bits. When the counter crosses zero it fetches one or more bytes from the bitstream byte FIFO, with stall support. Each fetched byte is issued to the `m_value` register together with its insertion shift. It sits between the byte FIFO and the value/range datapath.

## Interface
Parameters:
- `MAX_BYPASS_BITS`, 16: maximum bits one bypass op may consume (1..16).
- `BYTE_W`, 8: byte width; fixed at 8, present for lint uniformity.

Ports:
- `clk`  in  1  clock. One clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `init`  in  1  sync slice start: counter to -8, abort any fetch.
- `op_valid`  in  1  operation offered.
- `op_ready`  out  1  tracker can accept an op.
- `op_bypass`  in  1  1 = bypass run, 0 = regular renorm.
- `op_numbits`  in  5  bits consumed; regular 0..7, bypass 1..`MAX_BYPASS_BITS`.
- `byte_valid`  in  1  FIFO byte available.
- `byte_ready`  out  1  tracker takes byte this cycle.
- `byte_data`  in  8  FIFO byte.
- `ld_valid`  out  1  one-cycle pulse: load byte into value register.
- `ld_byte`  out  8  byte to load.
- `ld_shift`  out  5  left shift applied to `ld_byte` before adding to `m_value`.
- `bits_needed`  out  `CNT_W`  current signed counter, two's complement.
- `err`  out  1  sticky illegal-op flag.

## Operation
- Local param `CNT_W = $clog2(MAX_BYPASS_BITS+8)+1`. The counter `bn` lives in range -8..-1 between ops.
- Two states.
  - IDLE: `op_ready`=1, `byte_ready`=0.
  - FETCH: `op_ready`=0, `byte_ready`=1.
- IDLE, op accepted: `s = bn + op_numbits`, computed sign-extended.
  - If `s < 0`: `bn <= s`; stay IDLE.
  - Else: `acc <= s`; go to FETCH.
- Regular ops with `op_numbits` 0 are legal and leave `bn` unchanged. This is the MPS-without-renorm case.
- FETCH, on `byte_valid && byte_ready`:
  - Register `ld_valid`=1, `ld_byte = byte_data`, `ld_shift = acc`.
  - `acc <= acc - 8`.
  - If `acc - 8 < 0`: `bn <= acc - 8`; go to IDLE. Otherwise stay in FETCH for the next byte.
- Bypass with `s >= 8` needs two bytes: shifts `s`, then `s-8`.
- Without a byte handshake, FETCH holds all state. This is a stall.
- Illegal op: regular with `op_numbits > 7`, or bypass with `op_numbits` 0 or above `MAX_BYPASS_BITS`.
  - Sets `err`, which clears only on `init` or reset.
  - The op is still accepted, with `op_numbits` clamped to the legal max.
- `init` has priority over everything, in any state:
  - `bn <= -8`, state IDLE, `ld_valid <= 0`.
  - A byte offered that cycle is not taken: `byte_ready` is forced 0 while `init`=1.
- Values at reset: state IDLE, `bn` = -8, `acc` = 0, `ld_valid` = 0, `ld_byte` = 0, `ld_shift` = 0, `err` = 0. Resulting outputs: `op_ready` = 1, `byte_ready` = 0.

## Timing
- Op with `s < 0`: `bits_needed` updates at the next edge. Back-to-back ops are accepted every cycle.
- One-byte fetch with byte available:
  - Op accepted in cycle 0.
  - Byte handshake in cycle 1.
  - `ld_valid` high and `op_ready` high in cycle 2.
  - Throughput: one op per 2 cycles.
- Two-byte fetch: handshakes in cycles 1 and 2, `ld_valid` pulses in cycles 2 and 3, `op_ready` returns in cycle 3.
- `byte_ready` is driven from state only, with no combinational path from `byte_valid`.
- `op_ready` is driven from state only.

## Configuration
- `CABAC_BITS_TRACKER_STATS_EN` defined: adds two outputs.
  - `stat_bytes`, 32 bits: counts byte handshakes.
  - `stat_stalls`, 32 bits: counts FETCH cycles with `byte_valid`=0.
  - Both are zeroed by reset and `init`, and wrap at 2^32.
- Not defined: both ports and both counters are absent. Core behaviour is identical either way.

## Structure
- Shared `cabac_pkg` holds:
  - state enum `bt_state_t` {`BT_IDLE`, `BT_FETCH`};
  - `BN_INIT` = -8;
  - `CABAC_BYTE_W` = 8;
  - `REG_MAX_SHIFT` = 7.
- The stats counters go in one sub-module, `cabac_bits_stats`, which is instantiated only under the macro.
- Everything else stays in this module.

## Test plan
- After reset, regular op `numbits`=3 → `bits_needed` = -5, no `byte_ready`, `op_ready` stays 1.
- `bn`=-2, regular `numbits`=5, byte 0xA5 valid → `ld_valid` pulse with `ld_byte` 0xA5, `ld_shift` 3; then `bits_needed` = -5, 2 cycles to `op_ready`.
- `bn`=-1, bypass `numbits`=16, bytes 0x12, 0x34 → `ld_shift` 15 then 7; final `bits_needed` = -1.
- FETCH with `byte_valid` low for 4 cycles → state held, `stat_bytes` +1 and `stat_stalls` +4 under the macro.
- Assert `init` in FETCH with `byte_valid`=1 → no byte taken, `bits_needed` = -8, IDLE next cycle.
- Regular `numbits`=9 → `err`=1, treated as 7; `err` stays set until `init`.
